irq_priority_controller: RTL and testbench

Interrupt front-end for the 8-source priority encoding path. Captures rising edges on eight request lines into pending bits and applies a per-source enable mask. Presents the highest-index enabled pending source as a 3-bit ID under a valid/ready handshake, and clears that pending bit when the consumer accepts it. Sits directly upstream of the interrupt consumer and implements the 8-to-3 priority function as registered, handshaked state.

---
 rtl/irq_priority_controller_if.sv | 22 ++
 rtl/irq_priority_controller.sv | 73 +++++++
 tb/tb_irq_priority_controller.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/irq_priority_controller_if.sv
// Request/mask inputs and the handshaked ID output of the interrupt priority front-end.
// The producer/consumer side uses master; the controller uses slave.
interface irq_priority_controller_if;
  logic [7:0] req;
  logic [7:0] mask;
  logic       irq_ready;
  logic       ovf_clr;
  logic       irq_valid;
  logic [2:0] irq_id;
  logic [7:0] pending;
  logic       overflow;

  modport master (
    output req, mask, irq_ready, ovf_clr,
    input  irq_valid, irq_id, pending, overflow
  );

  modport slave (
    input  req, mask, irq_ready, ovf_clr,
    output irq_valid, irq_id, pending, overflow
  );
endinterface

// File: rtl/irq_priority_controller.sv
// 8-source interrupt front-end: edge/level capture into pending bits, masked
// priority pick (index 7 highest), registered ID under a valid/ready handshake.
module irq_priority_controller #(
  parameter bit LEVEL = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  irq_priority_controller_if.slave   irq
);

  logic [7:0] req_q;
  logic [7:0] pend_q, pend_d;
  logic       valid_q, valid_d;
  logic [2:0] id_q, id_d;
  logic       ovf_q, ovf_d;

  logic [7:0] rise;
  logic [7:0] clr;
  logic [7:0] cand;
  logic [2:0] winner;
  logic       acc;

  always_comb begin
    rise    = LEVEL ? irq.req : (irq.req & ~req_q);
    acc     = valid_q & irq.irq_ready;
    clr     = acc ? (8'd1 << id_q) : 8'd0;
    // Set beats clear when a source re-rises in the cycle it is accepted.
    pend_d  = (pend_q & ~clr) | rise;

    ovf_d   = ovf_q;
    if (irq.ovf_clr)
      ovf_d = 1'b0;
    if (!LEVEL && (|(rise & pend_q & ~clr)))
      ovf_d = 1'b1;

    cand    = pend_d & irq.mask;
    winner  = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (cand[i])
        winner = 3'(i);
    end

    // Output only reloads when idle or on accept; a stalled ID is never retracted.
    valid_d = valid_q;
    id_d    = id_q;
    if (!valid_q || acc) begin
      valid_d = |cand;
      id_d    = winner;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q   <= 8'd0;
      pend_q  <= 8'd0;
      valid_q <= 1'b0;
      id_q    <= 3'd0;
      ovf_q   <= 1'b0;
    end else begin
      req_q   <= irq.req;
      pend_q  <= pend_d;
      valid_q <= valid_d;
      id_q    <= id_d;
      ovf_q   <= ovf_d;
    end
  end

  assign irq.irq_valid = valid_q;
  assign irq.irq_id    = id_q;
  assign irq.pending   = pend_q;
  assign irq.overflow  = ovf_q;

endmodule

// File: tb/tb_irq_priority_controller.sv
// Directed bench for irq_priority_controller (edge-capture mode).
module tb_irq_priority_controller;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  irq_priority_controller_if bus ();

  irq_priority_controller #(.LEVEL(1'b0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .irq   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.req = 8'hFF; bus.mask = 8'hFF; bus.irq_ready = 1'b0; bus.ovf_clr = 1'b0;
    #12;
    checks++; if (bus.irq_valid !== 1'b0) begin errors++; $display("FAIL rst_valid actual=%0b required=0", bus.irq_valid); end
    checks++; if (bus.irq_id !== 3'd0) begin errors++; $display("FAIL rst_id actual=%0d required=0", bus.irq_id); end
    checks++; if (bus.pending !== 8'h00) begin errors++; $display("FAIL rst_pending actual=%h required=00", bus.pending); end
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL rst_overflow actual=%0b required=0", bus.overflow); end
    #10 rst_n = 1'b1;
    step();
    bus.req = 8'h00;
    checks++; if (bus.pending !== 8'hFF) begin errors++; $display("FAIL rel_pending actual=%h required=ff", bus.pending); end
    checks++; if (bus.irq_valid !== 1'b1 || bus.irq_id !== 3'd7) begin errors++; $display("FAIL rel_present actual=%0b/%0d required=1/7", bus.irq_valid, bus.irq_id); end
    bus.irq_ready = 1'b1;
    for (int i = 6; i >= 0; i--) begin
      step();
      checks++; if (bus.irq_valid !== 1'b1 || bus.irq_id !== 3'(i)) begin errors++; $display("FAIL rel_drain actual=%0b/%0d required=1/%0d", bus.irq_valid, bus.irq_id, i); end
    end
    step();
    checks++; if (bus.irq_valid !== 1'b0 || bus.irq_id !== 3'd0 || bus.pending !== 8'h00) begin errors++; $display("FAIL rel_empty actual=%0b/%0d/%h required=0/0/00", bus.irq_valid, bus.irq_id, bus.pending); end
    bus.irq_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [2:0] exp_ids [4];
    exp_ids = '{3'd7, 3'd5, 3'd2, 3'd0};
    bus.mask = 8'hFF; bus.irq_ready = 1'b1;
    bus.req = 8'b1010_0101;
    step();
    bus.req = 8'h00;
    checks++; if (bus.pending !== 8'hA5) begin errors++; $display("FAIL b2b_pending actual=%h required=a5", bus.pending); end
    for (int i = 0; i < 4; i++) begin
      if (i > 0) step();
      checks++; if (bus.irq_valid !== 1'b1 || bus.irq_id !== exp_ids[i]) begin errors++; $display("FAIL b2b_id actual=%0b/%0d required=1/%0d", bus.irq_valid, bus.irq_id, exp_ids[i]); end
    end
    step();
    checks++; if (bus.irq_valid !== 1'b0 || bus.pending !== 8'h00) begin errors++; $display("FAIL b2b_empty actual=%0b/%h required=0/00", bus.irq_valid, bus.pending); end
    bus.irq_ready = 1'b0;
  endtask

  task automatic test_hold();
    bus.mask = 8'hFF; bus.irq_ready = 1'b0;
    bus.req = 8'h08;
    step();
    bus.req = 8'h00;
    checks++; if (bus.irq_valid !== 1'b1 || bus.irq_id !== 3'd3) begin errors++; $display("FAIL hold_first actual=%0b/%0d required=1/3", bus.irq_valid, bus.irq_id); end
    step();
    bus.req = 8'h40; bus.mask = 8'hF7;
    step();
    bus.req = 8'h00;
    checks++; if (bus.irq_id !== 3'd3 || bus.pending !== 8'h48) begin errors++; $display("FAIL hold_frozen actual=%0d/%h required=3/48", bus.irq_id, bus.pending); end
    step();
    checks++; if (bus.irq_valid !== 1'b1 || bus.irq_id !== 3'd3) begin errors++; $display("FAIL hold_still actual=%0b/%0d required=1/3", bus.irq_valid, bus.irq_id); end
    bus.irq_ready = 1'b1;
    step();
    bus.irq_ready = 1'b0;
    checks++; if (bus.irq_valid !== 1'b1 || bus.irq_id !== 3'd6) begin errors++; $display("FAIL hold_next actual=%0b/%0d required=1/6", bus.irq_valid, bus.irq_id); end
    checks++; if (bus.pending !== 8'h40) begin errors++; $display("FAIL hold_pend3 actual=%h required=40", bus.pending); end
    bus.irq_ready = 1'b1;
    step();
    bus.irq_ready = 1'b0; bus.mask = 8'hFF;
    checks++; if (bus.irq_valid !== 1'b0) begin errors++; $display("FAIL hold_drain actual=%0b required=0", bus.irq_valid); end
  endtask

  task automatic test_masking();
    bus.mask = 8'h0F; bus.req = 8'hF0;
    step();
    bus.req = 8'h00;
    step();
    checks++; if (bus.irq_valid !== 1'b0 || bus.pending !== 8'hF0) begin errors++; $display("FAIL mask_block actual=%0b/%h required=0/f0", bus.irq_valid, bus.pending); end
    bus.mask = 8'hFF;
    step();
    checks++; if (bus.irq_valid !== 1'b1 || bus.irq_id !== 3'd7) begin errors++; $display("FAIL mask_open actual=%0b/%0d required=1/7", bus.irq_valid, bus.irq_id); end
    bus.irq_ready = 1'b1;
    repeat (4) step();
    bus.irq_ready = 1'b0;
    checks++; if (bus.irq_valid !== 1'b0 || bus.pending !== 8'h00) begin errors++; $display("FAIL mask_drain actual=%0b/%h required=0/00", bus.irq_valid, bus.pending); end
  endtask

  task automatic test_overflow();
    bus.mask = 8'hFF; bus.irq_ready = 1'b0;
    bus.req = 8'h04; step(); bus.req = 8'h00; step();
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL ovf_first actual=%0b required=0", bus.overflow); end
    bus.req = 8'h04; step(); bus.req = 8'h00;
    checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_set actual=%0b required=1", bus.overflow); end
    step();
    bus.req = 8'h04; bus.ovf_clr = 1'b1; step(); bus.req = 8'h00; bus.ovf_clr = 1'b0;
    checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_setwins actual=%0b required=1", bus.overflow); end
    step();
    bus.ovf_clr = 1'b1; step(); bus.ovf_clr = 1'b0;
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL ovf_clr actual=%0b required=0", bus.overflow); end
    bus.irq_ready = 1'b1; step(); bus.irq_ready = 1'b0;
    checks++; if (bus.irq_valid !== 1'b0 || bus.pending !== 8'h00) begin errors++; $display("FAIL ovf_drain actual=%0b/%h required=0/00", bus.irq_valid, bus.pending); end
  endtask

  task automatic test_collision();
    bus.mask = 8'hFF; bus.irq_ready = 1'b0;
    bus.req = 8'h10; step(); bus.req = 8'h00; step();
    checks++; if (bus.irq_valid !== 1'b1 || bus.irq_id !== 3'd4) begin errors++; $display("FAIL col_first actual=%0b/%0d required=1/4", bus.irq_valid, bus.irq_id); end
    bus.irq_ready = 1'b1; bus.req = 8'h10;
    step();
    bus.req = 8'h00; bus.irq_ready = 1'b0;
    checks++; if (bus.pending !== 8'h10 || bus.overflow !== 1'b0) begin errors++; $display("FAIL col_pend actual=%h/%0b required=10/0", bus.pending, bus.overflow); end
    checks++; if (bus.irq_valid !== 1'b1 || bus.irq_id !== 3'd4) begin errors++; $display("FAIL col_repres actual=%0b/%0d required=1/4", bus.irq_valid, bus.irq_id); end
    bus.irq_ready = 1'b1; step(); bus.irq_ready = 1'b0;
    checks++; if (bus.irq_valid !== 1'b0) begin errors++; $display("FAIL col_drain actual=%0b required=0", bus.irq_valid); end
  endtask

  task automatic test_reset_mid();
    bus.mask = 8'hFF; bus.irq_ready = 1'b0;
    bus.req = 8'h81; step(); bus.req = 8'h00;
    checks++; if (bus.irq_valid !== 1'b1 || bus.irq_id !== 3'd7) begin errors++; $display("FAIL mid_pre actual=%0b/%0d required=1/7", bus.irq_valid, bus.irq_id); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.irq_valid !== 1'b0 || bus.irq_id !== 3'd0 || bus.pending !== 8'h00) begin errors++; $display("FAIL mid_async actual=%0b/%0d/%h required=0/0/00", bus.irq_valid, bus.irq_id, bus.pending); end
    #2 rst_n = 1'b1;
    step();
    checks++; if (bus.irq_valid !== 1'b0 || bus.pending !== 8'h00) begin errors++; $display("FAIL mid_after actual=%0b/%h required=0/00", bus.irq_valid, bus.pending); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_back_to_back();
    test_hold();
    test_masking();
    test_overflow();
    test_collision();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
